agg_classifier_demux: RTL and testbench

// Next-generation aggregation datapath front end. Sits between the RX queue and the output side.

---
 rtl/agg_classifier_demux_pkg.sv | 30 +++
 rtl/agg_sat_counter.sv | 26 ++
 rtl/agg_classifier_demux.sv | 202 ++++++++++++++++++++
 tb/tb_agg_classifier_demux.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/agg_classifier_demux_pkg.sv
// Shared types and constants for the aggregation classifier/demux.
// Holds FSM state encoding, match-mode codes and the match helper.
package agg_classifier_demux_pkg;

  typedef enum logic [1:0] {
    ST_PARSE = 2'd0,
    ST_SEND  = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  localparam logic [1:0] MM_ET_AND_AC = 2'd0;
  localparam logic [1:0] MM_ET_OR_AC  = 2'd1;
  localparam logic [1:0] MM_ET_ONLY   = 2'd2;
  localparam logic [1:0] MM_NEVER     = 2'd3;

  localparam int CH_OQ = 0;

  function automatic logic mode_match(input logic [1:0] mode, input logic et_hit,
                                      input logic ac_hit);
    logic hit;
    case (mode)
      MM_ET_AND_AC: hit = et_hit & ac_hit;
      MM_ET_OR_AC:  hit = et_hit | ac_hit;
      MM_ET_ONLY:   hit = et_hit;
      default:      hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/agg_sat_counter.sv
// Saturating event counter with synchronous clear; clear has priority over inc.
module agg_sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 axis_aclk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_reg;

  always_ff @(posedge axis_aclk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/agg_classifier_demux.sv
// Buffers AXI4-Stream packets, classifies each on its first beat (EtherType/app-code)
// and steers the whole packet to one of NUM_CHANNELS masters or drops it.
module agg_classifier_demux
  import agg_classifier_demux_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_CHANNELS       = 4,
  parameter int ETHER_TYPE_POS     = 96,
  parameter int APP_CODE_POS       = 112,
  parameter int APP_CODE_WIDTH     = 2,
  parameter int FIFO_DEPTH_BITS    = 6,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                                axis_aclk,
  input  logic                                axis_resetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]        s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]      s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]       s_axis_tuser,
  input  logic                                s_axis_tvalid,
  input  logic                                s_axis_tlast,
  output logic                                s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]        m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]      m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]       m_axis_tuser,
  output logic                                m_axis_tlast,
  output logic [NUM_CHANNELS-1:0]             m_axis_tvalid,
  input  logic [NUM_CHANNELS-1:0]             m_axis_tready,
  input  logic [1:0]                          cfg_match_mode,
  input  logic [15:0]                         cfg_ethertype,
  input  logic [APP_CODE_WIDTH-1:0]           cfg_appcode,
  input  logic [NUM_CHANNELS-1:0]             cfg_chan_en,
  input  logic                                cnt_clear,
  output logic [CNT_WIDTH-1:0]                pkt_in_cnt,
  output logic [NUM_CHANNELS*CNT_WIDTH-1:0]   pkt_out_cnt,
  output logic [CNT_WIDTH-1:0]                pkt_drop_cnt
);

  localparam int KW    = C_AXIS_DATA_WIDTH / 8;
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int CH_W  = $clog2(NUM_CHANNELS);

  if ((ETHER_TYPE_POS + 16 > C_AXIS_DATA_WIDTH) ||
      (APP_CODE_POS + APP_CODE_WIDTH > C_AXIS_DATA_WIDTH) ||
      (NUM_CHANNELS < 2) || (NUM_CHANNELS > 8)) begin : g_param_check
    $error("agg_classifier_demux: field positions or NUM_CHANNELS out of range");
  end

  typedef struct packed {
    logic [C_AXIS_DATA_WIDTH-1:0]  data;
    logic [KW-1:0]                 keep;
    logic [C_AXIS_TUSER_WIDTH-1:0] user;
    logic                          last;
  } beat_t;

  // Reset asserts asynchronously but is released on a clock edge.
  logic [1:0] rst_sync_reg;
  logic       rst_n;

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) rst_sync_reg <= 2'b00;
    else              rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_n = rst_sync_reg[1];

  // Fall-through input FIFO: head entry is visible without a read.
  beat_t                      mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_DEPTH_BITS:0]   count_reg;
  logic                       fifo_wr, fifo_rd, fifo_empty, nearly_full;
  beat_t                      wr_beat, head;

  assign wr_beat       = '{data: s_axis_tdata, keep: s_axis_tkeep, user: s_axis_tuser,
                           last: s_axis_tlast};
  assign nearly_full   = count_reg >= (FIFO_DEPTH_BITS+1)'(DEPTH - 1);
  assign fifo_empty    = (count_reg == '0);
  assign s_axis_tready = rst_n & ~nearly_full;
  assign fifo_wr       = s_axis_tvalid & s_axis_tready;
  assign head          = mem[rd_ptr_reg];

  always_ff @(posedge axis_aclk) begin
    if (fifo_wr) mem[wr_ptr_reg] <= wr_beat;
  end

  always_ff @(posedge axis_aclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (fifo_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (fifo_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({fifo_wr, fifo_rd})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign m_axis_tdata = head.data;
  assign m_axis_tkeep = head.keep;
  assign m_axis_tuser = head.user;
  assign m_axis_tlast = head.last;

  // Classification of the head beat; only consumed while in PARSE.
  logic [APP_CODE_WIDTH-1:0] head_ac;
  logic                      et_hit, ac_hit;
  logic [CH_W-1:0]           route_calc;

  assign head_ac = head.data[APP_CODE_POS +: APP_CODE_WIDTH];

  always_comb begin
    et_hit = (head.data[ETHER_TYPE_POS +: 16] == cfg_ethertype);
    ac_hit = (head_ac == cfg_appcode);
    if (mode_match(cfg_match_mode, et_hit, ac_hit))
      route_calc = CH_W'(1 + (int'(head_ac) % (NUM_CHANNELS - 1)));
    else
      route_calc = CH_W'(CH_OQ);
  end

  state_t          state_reg, state_next;
  logic [CH_W-1:0] route_reg, route_next;
  logic            out_done, drop_done;

  always_ff @(posedge axis_aclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_PARSE;
      route_reg <= '0;
    end else begin
      state_reg <= state_next;
      route_reg <= route_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    route_next    = route_reg;
    fifo_rd       = 1'b0;
    out_done      = 1'b0;
    drop_done     = 1'b0;
    m_axis_tvalid = '0;
    case (state_reg)
      ST_PARSE: begin
        // Decision cycle: nothing is popped, giving one bubble per packet.
        if (!fifo_empty) begin
          route_next = route_calc;
          state_next = cfg_chan_en[route_calc] ? ST_SEND : ST_DROP;
        end
      end
      ST_SEND: begin
        if (!fifo_empty) begin
          m_axis_tvalid[route_reg] = 1'b1;
          if (m_axis_tready[route_reg]) begin
            fifo_rd = 1'b1;
            if (head.last) begin
              out_done   = 1'b1;
              state_next = ST_PARSE;
            end
          end
        end
      end
      ST_DROP: begin
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          if (head.last) begin
            drop_done  = 1'b1;
            state_next = ST_PARSE;
          end
        end
      end
      default: state_next = ST_PARSE;
    endcase
  end

  agg_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_in_cnt (
    .axis_aclk (axis_aclk),
    .rst_n     (rst_n),
    .clear     (cnt_clear),
    .inc       (fifo_wr & s_axis_tlast),
    .count     (pkt_in_cnt)
  );

  agg_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_drop_cnt (
    .axis_aclk (axis_aclk),
    .rst_n     (rst_n),
    .clear     (cnt_clear),
    .inc       (drop_done),
    .count     (pkt_drop_cnt)
  );

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_out_cnt
    agg_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_out_cnt (
      .axis_aclk (axis_aclk),
      .rst_n     (rst_n),
      .clear     (cnt_clear),
      .inc       (out_done && (route_reg == CH_W'(gi))),
      .count     (pkt_out_cnt[gi*CNT_WIDTH +: CNT_WIDTH])
    );
  end

endmodule

// File: tb/tb_agg_classifier_demux.sv
// Directed bench for agg_classifier_demux: scoreboard of expected output beats,
// counter model with saturation, reset, drop, backpressure and bubble checks.
module tb_agg_classifier_demux;

  localparam int DW = 256, UW = 128, NCH = 4, ETP = 96, ACP = 112, ACW = 2;
  localparam int FDB = 4, CW = 4, KW = DW / 8;

  logic                 axis_aclk = 1'b0;
  logic                 axis_resetn = 1'b0;
  logic [DW-1:0]        s_axis_tdata = '0;
  logic [KW-1:0]        s_axis_tkeep = '0;
  logic [UW-1:0]        s_axis_tuser = '0;
  logic                 s_axis_tvalid = 1'b0;
  logic                 s_axis_tlast = 1'b0;
  logic                 s_axis_tready;
  logic [DW-1:0]        m_axis_tdata;
  logic [KW-1:0]        m_axis_tkeep;
  logic [UW-1:0]        m_axis_tuser;
  logic                 m_axis_tlast;
  logic [NCH-1:0]       m_axis_tvalid;
  logic [NCH-1:0]       m_axis_tready = '1;
  logic [1:0]           cfg_match_mode = 2'd0;
  logic [15:0]          cfg_ethertype = 16'h8888;
  logic [ACW-1:0]       cfg_appcode = 2'd1;
  logic [NCH-1:0]       cfg_chan_en = '1;
  logic                 cnt_clear = 1'b0;
  logic [CW-1:0]        pkt_in_cnt;
  logic [NCH*CW-1:0]    pkt_out_cnt;
  logic [CW-1:0]        pkt_drop_cnt;

  agg_classifier_demux #(
    .C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW), .NUM_CHANNELS(NCH),
    .ETHER_TYPE_POS(ETP), .APP_CODE_POS(ACP), .APP_CODE_WIDTH(ACW),
    .FIFO_DEPTH_BITS(FDB), .CNT_WIDTH(CW)
  ) dut (
    .axis_aclk(axis_aclk), .axis_resetn(axis_resetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .cfg_match_mode(cfg_match_mode), .cfg_ethertype(cfg_ethertype), .cfg_appcode(cfg_appcode),
    .cfg_chan_en(cfg_chan_en), .cnt_clear(cnt_clear),
    .pkt_in_cnt(pkt_in_cnt), .pkt_out_cnt(pkt_out_cnt), .pkt_drop_cnt(pkt_drop_cnt)
  );

  always #5 axis_aclk = ~axis_aclk;

  typedef struct packed {
    logic [2:0]    ch;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } obs_t;

  obs_t           exp_q[$];
  int             pop_cyc_q[$];
  int             n_cmp = 0, n_err = 0;
  int             cyc = 0;
  logic [NCH-1:0] rdy_base = '1;
  bit             bp_en = 1'b0;
  logic [CW-1:0]  exp_in = '0, exp_drop = '0;
  logic [CW-1:0]  exp_out [NCH];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge axis_aclk);
    cyc++;
  end

  // Sole driver of m_axis_tready; optional random stalls on ch1.
  initial forever begin
    @(posedge axis_aclk);
    #2;
    m_axis_tready = rdy_base;
    if (bp_en) m_axis_tready[1] = ($urandom_range(99) >= 30);
  end

  // Output monitor: hold rule, one-hot valid, scoreboard compare on each handshake.
  initial begin
    obs_t cur, prev_obs, e;
    bit   prev_pending;
    prev_pending = 1'b0;
    prev_obs = '0;
    forever begin
      @(negedge axis_aclk);
      if (!axis_resetn) begin
        prev_pending = 1'b0;
      end else begin
        cur.ch = 3'd7;
        for (int c = 0; c < NCH; c++) if (m_axis_tvalid[c]) cur.ch = 3'(c);
        cur.data = m_axis_tdata;
        cur.keep = m_axis_tkeep;
        cur.user = m_axis_tuser;
        cur.last = m_axis_tlast;
        if (m_axis_tvalid != '0) chk("tvalid_onehot", 512'($onehot(m_axis_tvalid)), 512'(1));
        if (prev_pending) chk("axis_hold", cur, prev_obs);
        if ((m_axis_tvalid & m_axis_tready) != '0) begin
          n_cmp++;
          assert (exp_q.size() > 0) else begin
            n_err++;
            $error("FAIL unexpected_beat observed_ch=%0d expected=none", cur.ch);
          end
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_beat", cur, e);
          end
          pop_cyc_q.push_back(cyc);
          prev_pending = 1'b0;
        end else begin
          prev_pending = (m_axis_tvalid != '0);
          prev_obs = cur;
        end
      end
    end
  end

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic int model_route(input logic [15:0] et, input logic [ACW-1:0] ac);
    bit eh, ah, m;
    eh = (et == cfg_ethertype);
    ah = (ac == cfg_appcode);
    case (cfg_match_mode)
      2'd0:    m = eh && ah;
      2'd1:    m = eh || ah;
      2'd2:    m = eh;
      default: m = 1'b0;
    endcase
    return m ? 1 + (int'(ac) % (NCH - 1)) : 0;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic drive_beat(input obs_t b);
    int n;
    bit ok;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = b.data;
    s_axis_tkeep  = b.keep;
    s_axis_tuser  = b.user;
    s_axis_tlast  = b.last;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 2000) begin
      @(negedge axis_aclk);
      ok = s_axis_tready;
      @(posedge axis_aclk);
      #1;
      n++;
    end
    if (!ok) chk("s_tready_timeout", 512'(ok), 512'(1));
  endtask

  task automatic send_pkt(input logic [15:0] et, input logic [ACW-1:0] ac, input int nb,
                          input int flip_at, input logic [15:0] flip_et);
    int   r;
    bit   drop;
    obs_t b;
    r = model_route(et, ac);
    drop = !cfg_chan_en[r];
    for (int i = 0; i < nb; i++) begin
      b.ch   = 3'(r);
      b.data = rand_data();
      b.keep = $urandom;
      b.user = {$urandom, $urandom, $urandom, $urandom};
      b.last = (i == nb - 1);
      if (i == 0) begin
        b.data[ETP +: 16]  = et;
        b.data[ACP +: ACW] = ac;
      end
      if (!drop) exp_q.push_back(b);
      drive_beat(b);
      if (i == flip_at) cfg_ethertype = flip_et;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    exp_in = sat_inc(exp_in);
    if (drop) exp_drop = sat_inc(exp_drop);
    else      exp_out[r] = sat_inc(exp_out[r]);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge axis_aclk);
      n++;
    end
    repeat (20) @(posedge axis_aclk);
    #1;
    if (exp_q.size() != 0) chk("drain_timeout", 512'(exp_q.size()), 512'(0));
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_in_cnt"}, 512'(pkt_in_cnt), 512'(exp_in));
    for (int c = 0; c < NCH; c++)
      chk($sformatf("%s_out_cnt%0d", tag, c), 512'(pkt_out_cnt[c*CW +: CW]), 512'(exp_out[c]));
    chk({tag, "_drop_cnt"}, 512'(pkt_drop_cnt), 512'(exp_drop));
  endtask

  task automatic zero_model();
    exp_in = '0;
    exp_drop = '0;
    for (int c = 0; c < NCH; c++) exp_out[c] = '0;
  endtask

  initial begin
    zero_model();
    repeat (3) @(posedge axis_aclk);
    #1 axis_resetn = 1'b1;
    repeat (4) @(posedge axis_aclk);
    #1;
    chk("reset_tvalid", 512'(m_axis_tvalid), 512'(0));
    chk("reset_s_tready", 512'(s_axis_tready), 512'(1));
    check_counters("reset");

    // mode 0, ET 8888 AC 1 -> ch2
    send_pkt(16'h8888, 2'd1, 3, -1, 16'h0);
    wait_idle();
    check_counters("mode0_match");

    cfg_match_mode = 2'd1;
    send_pkt(16'h0800, 2'd1, 2, -1, 16'h0);
    wait_idle();
    cfg_match_mode = 2'd0;
    send_pkt(16'h0800, 2'd1, 2, -1, 16'h0);
    wait_idle();
    cfg_match_mode = 2'd3;
    send_pkt(16'h8888, 2'd1, 2, -1, 16'h0);
    wait_idle();
    cfg_match_mode = 2'd2;
    send_pkt(16'h8888, 2'd3, 1, -1, 16'h0);
    wait_idle();
    check_counters("modes");

    // Disabled ch2 drops the packet; the next one routes normally.
    cfg_match_mode = 2'd0;
    cfg_chan_en = 4'b1011;
    send_pkt(16'h8888, 2'd1, 3, -1, 16'h0);
    wait_idle();
    check_counters("drop");
    cfg_match_mode = 2'd2;
    send_pkt(16'h8888, 2'd0, 2, -1, 16'h0);
    wait_idle();
    cfg_chan_en = '1;
    check_counters("after_drop");

    // EtherType changes mid-packet: current packet keeps ch2, next goes to ch0.
    cfg_match_mode = 2'd0;
    send_pkt(16'h8888, 2'd1, 5, 2, 16'h0800);
    send_pkt(16'h8888, 2'd1, 2, -1, 16'h0);
    wait_idle();
    check_counters("cfg_flip");
    cfg_ethertype = 16'h8888;

    // Back-to-back random packets with stalls on ch1.
    cfg_match_mode = 2'd2;
    bp_en = 1'b1;
    for (int p = 0; p < 20; p++)
      send_pkt(($urandom_range(1) != 0) ? 16'h8888 : 16'h1234, 2'($urandom_range(3)),
               $urandom_range(8, 1), -1, 16'h0);
    wait_idle();
    bp_en = 1'b0;
    check_counters("backpressure");

    // All outputs stalled: input must throttle once the FIFO is nearly full.
    cfg_match_mode = 2'd3;
    rdy_base = '0;
    fork
      send_pkt(16'h1111, 2'd0, 20, -1, 16'h0);
      begin
        repeat (25) @(posedge axis_aclk);
        #1;
        chk("nearly_full_tready", 512'(s_axis_tready), 512'(0));
        chk("stalled_tvalid", 512'(m_axis_tvalid), 512'(4'b0001));
        rdy_base = '1;
      end
    join
    wait_idle();

    // Exactly one bubble cycle between back-to-back packets.
    pop_cyc_q.delete();
    send_pkt(16'h1111, 2'd0, 2, -1, 16'h0);
    send_pkt(16'h2222, 2'd0, 2, -1, 16'h0);
    wait_idle();
    chk("bubble_pops", 512'(pop_cyc_q.size()), 512'(4));
    if (pop_cyc_q.size() == 4) begin
      chk("bubble_intra", 512'(pop_cyc_q[1] - pop_cyc_q[0]), 512'(1));
      chk("bubble_gap", 512'(pop_cyc_q[2] - pop_cyc_q[1]), 512'(2));
    end

    // Reset while a packet is stalled on ch2.
    cfg_match_mode = 2'd0;
    rdy_base = 4'b1011;
    send_pkt(16'h8888, 2'd1, 6, -1, 16'h0);
    repeat (3) @(posedge axis_aclk);
    #1;
    chk("pre_reset_tvalid", 512'(m_axis_tvalid), 512'(4'b0100));
    #2 axis_resetn = 1'b0;
    #1;
    chk("reset_async_tvalid", 512'(m_axis_tvalid), 512'(0));
    exp_q.delete();
    zero_model();
    repeat (3) @(posedge axis_aclk);
    #1 axis_resetn = 1'b1;
    rdy_base = '1;
    repeat (4) @(posedge axis_aclk);
    #1;
    chk("post_reset_tvalid", 512'(m_axis_tvalid), 512'(0));
    chk("post_reset_s_tready", 512'(s_axis_tready), 512'(1));
    check_counters("post_reset");
    send_pkt(16'h8888, 2'd1, 3, -1, 16'h0);
    wait_idle();
    check_counters("clean_pkt");

    // Counter saturation: clear, reach max-1, then push past the top.
    cnt_clear = 1'b1;
    @(posedge axis_aclk);
    #1 cnt_clear = 1'b0;
    zero_model();
    cfg_match_mode = 2'd3;
    for (int p = 0; p < 14; p++) send_pkt(16'h0, 2'd0, 1, -1, 16'h0);
    wait_idle();
    check_counters("max_minus_1");
    for (int p = 0; p < 3; p++) send_pkt(16'h0, 2'd0, 1, -1, 16'h0);
    wait_idle();
    chk("sat_in_cnt", 512'(pkt_in_cnt), 512'(4'hF));
    check_counters("saturated");

    // Clear coincident with an accepted tlast beat: clear wins.
    cnt_clear = 1'b1;
    send_pkt(16'h0, 2'd0, 1, -1, 16'h0);
    cnt_clear = 1'b0;
    zero_model();
    exp_out[0] = 4'd1;
    wait_idle();
    check_counters("clear_wins");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_cmp++;
    n_err++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
